// File: rtl/alu_issue.sv
// alu_issue: single-issue sequencer driving an external registered ALU over a 4x8 register file; `ALU_ISSUE_DBG_EN enables dbg_data read-back
module alu_issue #(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] instr,
    input  logic [7:0] imm,
    output logic       alu_en,
    output logic [2:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_out,
    input  logic       alu_zero,
    input  logic       alu_carry,
    output logic       done,
    output logic       flag_zero,
    output logic       flag_carry,
    input  logic [1:0] dbg_sel,
    output logic [7:0] dbg_data
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;
    localparam logic [2:0] OP_LDI = 3'b111;
    state_t     state, state_nx;
    logic [2:0] op;
    logic [1:0] rd, rs;
    logic [7:0] imm_q, res_q;
    logic       z_q, c_q;
    logic [7:0] rf [4];
    logic       is_ldi, unused_ok;
    assign is_ldi = op == OP_LDI;
    always_comb begin
        state_nx = state == IDLE  ? (in_valid ? (instr[7:5] == OP_LDI ? WB : ISSUE) : IDLE) :
                   state == ISSUE ? WAIT :
                   state == WAIT  ? WB : IDLE;
        in_ready = state == IDLE;
        alu_en   = state == ISSUE;
        done     = state == WB;
        alu_op   = alu_en ? op : 3'd0;
        alu_a    = alu_en ? rf[rd] : 8'd0;
        alu_b    = alu_en ? rf[rs] : 8'd0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            for (int i = 0; i < 4; i++) rf[i] <= RESET_VAL;
        end else begin
            state <= state_nx;
            if (in_valid && in_ready) begin
                op    <= instr[7:5];
                rd    <= instr[3:2];
                rs    <= instr[1:0];
                imm_q <= imm;
            end
            if (state == WAIT) begin
                res_q <= alu_out;
                z_q   <= alu_zero;
                c_q   <= alu_carry;
            end
            if (state == WB) begin
                rf[rd] <= is_ldi ? imm_q : res_q;
                if (!is_ldi) begin
                    flag_zero  <= z_q;
                    flag_carry <= c_q;
                end
            end
        end
    end
`ifdef ALU_ISSUE_DBG_EN
    assign dbg_data  = rf[dbg_sel];
    assign unused_ok = instr[4];
`else
    assign dbg_data  = 8'h00;
    assign unused_ok = ^{instr[4], dbg_sel};
`endif
endmodule
